// File: rtl/union_view_arbiter.sv
// union_view_arbiter: round-robin arbiter and sequencer for one shared
// packed-union register. Each access runs IDLE -> GRANT -> ACCESS and uses
// either the raw view or the split view, in which the two halves are exchanged.
//
// Handshake: a requester raises req[i] and holds it until gnt[i] rises.
// If req[i] is still high in GRANT, the access runs in the following ACCESS
// cycle. If req[i] drops during GRANT, the access is aborted. Read data is
// returned with a one-cycle rvalid pulse, and rdata holds its value until the
// next read.
//
// Optional feature: define UNION_ARB_LOCK_EN to add the lock input.
// When the owner has lock set during ACCESS, the pointer stays on that owner.
// The owner then wins the next arbitration again if it keeps requesting.
module union_view_arbiter #(
  parameter int                NREQ      = 4,
  parameter int                WIDTH     = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = 'hA
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         wr,
  input  logic [NREQ-1:0]         view,
  input  logic [NREQ*WIDTH-1:0]   wdata,
`ifdef UNION_ARB_LOCK_EN
  input  logic [NREQ-1:0]         lock,
`endif
  output logic [NREQ-1:0]         gnt,
  output logic                    rvalid,
  output logic [WIDTH-1:0]        rdata,
  output logic [WIDTH-1:0]        un_q,
  output logic [1:0]              dbg_state
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HALF = WIDTH / 2;

  // The two views of the shared register.
  typedef struct packed {
    logic [HALF-1:0] hi;
    logic [HALF-1:0] lo;
  } split_t;

  typedef union packed {
    logic [WIDTH-1:0] raw;
    split_t           split;
  } un_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] un_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;

  logic             pick_found;
  logic [PW-1:0]    pick_idx;
  logic [PW-1:0]    owner_next;
  logic [WIDTH-1:0] own_wdata;
  un_t              wr_view;
  un_t              rd_view;
  un_t              cur;

  // Returns the value seen through the split view, with the halves exchanged.
  function automatic logic [WIDTH-1:0] swap_halves(input logic [WIDTH-1:0] x);
    un_t u;
    u.raw = x;
    return {u.split.lo, u.split.hi};
  endfunction

  assign dbg_state  = state_q;
  assign rvalid     = rvalid_q;
  assign rdata      = rdata_q;
  assign owner_next = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
  assign own_wdata  = wdata[int'(owner_q)*WIDTH +: WIDTH];

  // Round-robin pick: the first requesting index at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      int            t;
      logic [PW-1:0] t_idx;
      t = int'(rr_ptr_q) + k;
      if (t >= NREQ) t = t - NREQ;
      t_idx = PW'(t);
      if (!pick_found && req[t_idx]) begin
        pick_found = 1'b1;
        pick_idx   = t_idx;
      end
    end
  end

  // Data written to the register and data read from it, through the owner's view.
  always_comb begin
    cur.raw     = un_q;
    wr_view.raw = view[owner_q] ? swap_halves(own_wdata) : own_wdata;
    rd_view.raw = view[owner_q] ? swap_halves(cur.raw) : cur.raw;
  end

  // Next-state logic, grant decode and the register update for each access.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    un_d     = un_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    gnt      = '0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        gnt[owner_q] = 1'b1;
        if (req[owner_q]) begin
          state_d = S_ACCESS;
        end else begin
          rr_ptr_d = owner_next;
          state_d  = S_IDLE;
        end
      end
      S_ACCESS: begin
        gnt[owner_q] = 1'b1;
        if (wr[owner_q]) begin
          un_d = wr_view.raw;
        end else begin
          rdata_d  = rd_view.raw;
          rvalid_d = 1'b1;
        end
        rr_ptr_d = owner_next;
`ifdef UNION_ARB_LOCK_EN
        if (lock[owner_q]) rr_ptr_d = owner_q;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers. Reset is asynchronous and drops any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      un_q     <= RESET_VAL;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      un_q     <= un_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

endmodule

// File: tb/tb_union_view_arbiter.sv
// tb_union_view_arbiter: directed bench for union_view_arbiter.
// A transaction-timeline model predicts gnt, rvalid, rdata and un_q for every cycle.
// Literal checks pin the model at the points the scenarios call out.
module tb_union_view_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]   req   = '0;
  logic [NREQ-1:0]   wr    = '0;
  logic [NREQ-1:0]   view  = '0;
  logic [NREQ-1:0]   lock  = '0;
  logic [NREQ*W-1:0] wdata = '0;
  logic [NREQ-1:0]   gnt;
  logic              rvalid;
  logic [W-1:0]      rdata;
  logic [W-1:0]      un_q;
  logic [1:0]        dbg_state;

  union_view_arbiter #(.NREQ(NREQ), .WIDTH(W), .RESET_VAL(4'hA)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .view(view), .wdata(wdata),
`ifdef UNION_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .un_q(un_q), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int compares = 0;
  int errors   = 0;
  int cyc      = 0;
  int rv_count = 0;
  int grant_log[$];
  int rv_cyc[$];
  logic [NREQ-1:0] prev_gnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compares++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] swap(input logic [W-1:0] x);
    return {x[W/2-1:0], x[W-1:W/2]};
  endfunction

  // ---------------- behavioural model ----------------
  // The owner is -1 when no access is in flight. age counts the cycles since the grant was issued.
  int           m_own   = -1;
  int           m_age   = 0;
  int           m_rr    = 0;
  logic [W-1:0] m_un    = 4'hA;
  logic [W-1:0] m_rdata = '0;
  logic [NREQ-1:0] m_gnt = '0;
  logic         m_rv    = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_own = -1; m_age = 0; m_rr = 0; m_un = 4'hA; m_rdata = '0; m_gnt = '0; m_rv = 1'b0;
    end else begin
      m_rv = 1'b0;
      if (m_own < 0) begin
        if (req != '0) begin
          bit found;
          found = 1'b0;
          for (int k = 0; k < NREQ; k++) begin
            if (!found && req[(m_rr + k) % NREQ]) begin
              found = 1'b1;
              m_own = (m_rr + k) % NREQ;
              m_age = 1;
            end
          end
        end
      end else if (m_age == 1) begin
        if (req[m_own]) m_age = 2;
        else begin
          m_rr  = (m_own + 1) % NREQ;
          m_own = -1;
        end
      end else begin
        logic [W-1:0] slice;
        slice = wdata[m_own*W +: W];
        if (wr[m_own]) m_un = view[m_own] ? swap(slice) : slice;
        else begin
          m_rdata = view[m_own] ? swap(m_un) : m_un;
          m_rv    = 1'b1;
        end
        m_rr = (m_own + 1) % NREQ;
`ifdef UNION_ARB_LOCK_EN
        if (lock[m_own]) m_rr = m_own;
`endif
        m_own = -1;
      end
      m_gnt = (m_own < 0) ? '0 : (NREQ'(1) << m_own);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: checks every output against the model on each falling edge.
  always @(negedge clk) begin
    check("gnt", gnt, m_gnt);
    check("rvalid", rvalid, m_rv);
    check("rdata", rdata, m_rdata);
    check("un_q", un_q, m_un);
    if (gnt != '0 && prev_gnt == '0) begin
      for (int i = 0; i < NREQ; i++) if (gnt[i]) grant_log.push_back(i);
    end
    if (rvalid) begin
      rv_count++;
      rv_cyc.push_back(cyc);
    end
    prev_gnt = gnt;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic drive(input int i, input bit w, input bit v, input logic [W-1:0] d, input bit on);
    req[i] = on; wr[i] = w; view[i] = v; wdata[i*W +: W] = d;
  endtask

  task automatic wait_gnt(input int i);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (gnt[i]) begin ok = 1'b1; break; end
    end
    check("gnt_wait", ok, 1'b1);
  endtask

  task automatic do_access(input int i, input bit w, input bit v, input logic [W-1:0] d);
    tick();
    drive(i, w, v, d, 1'b1);
    wait_gnt(i);
    @(posedge clk);
    @(posedge clk); #1;
    req[i] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rv0;
    int base;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: idle after reset
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("rst_un_q", un_q, 4'hA);
      check("rst_gnt", gnt, 4'h0);
      check("rst_rvalid", rvalid, 1'b0);
      check("rst_state", dbg_state, 2'd0);
    end

    // 2: raw write by requester 1, with exact latency
    tick();
    drive(1, 1'b1, 1'b0, 4'h3, 1'b1);
    @(negedge clk); check("t2_gnt_N", gnt, 4'b0000);
    @(negedge clk); check("t2_gnt_N1", gnt, 4'b0010);
    @(negedge clk); check("t2_gnt_N2", gnt, 4'b0010);
    @(posedge clk); #1 req[1] = 1'b0;
    @(negedge clk);
    check("t2_gnt_N3", gnt, 4'b0000);
    check("t2_un_N3", un_q, 4'h3);

    // 3: split-view read and split-view write
    do_access(0, 1'b1, 1'b0, 4'hA);
    rv0 = rv_count;
    do_access(2, 1'b0, 1'b1, 4'h0);
    settle();
    check("t3_rv_cnt", rv_count - rv0, 1);
    check("t3_rdata", rdata, 4'hA);
    do_access(2, 1'b1, 1'b1, 4'h1);
    settle();
    check("t3_split_wr", un_q, 4'h4);
    do_access(3, 1'b0, 1'b0, 4'h0);
    settle();
    check("t3_raw_rd", rdata, 4'h4);

    // 4: all four requesting reads -> rotation 0,1,2,3,0
    tick();
    base = grant_log.size();
    rv0  = rv_count;
    req = 4'hF; wr = 4'h0; view = 4'h0;
    repeat (15) @(posedge clk);
    #1 req = 4'h0;
    settle();
    check("t4_ngrants", grant_log.size() - base, 5);
    for (int k = 0; k < 5; k++)
      if (base + k < grant_log.size()) check("t4_order", grant_log[base + k], exp_order[k]);
    check("t4_rv_cnt", rv_count - rv0, 5);
    for (int k = rv_cyc.size() - 4; k < rv_cyc.size(); k++)
      if (k > 0) check("t4_rv_spacing", rv_cyc[k] - rv_cyc[k-1], 3);

    // 5: requester 3 drops in GRANT -> abort; the pointer moves to 0
    tick();
    rv0 = rv_count;
    drive(3, 1'b0, 1'b0, 4'h0, 1'b1);
    wait_gnt(3);
    req[3] = 1'b0;
    repeat (4) tick();
    check("t5_no_rv", rv_count - rv0, 0);
    check("t5_un_keep", un_q, 4'h4);
    base = grant_log.size();
    req = 4'b1001; wr = 4'h0;
    wait_gnt(0);
    @(posedge clk);
    @(posedge clk); #1 req = 4'h0;
    settle();
    check("t5_next_grant", (grant_log.size() > base) ? grant_log[base] : -1, 0);

    // 6: reset pulsed during ACCESS of a write
    tick();
    rv0 = rv_count;
    drive(1, 1'b1, 1'b0, 4'h5, 1'b1);
    wait_gnt(1);
    @(negedge clk);
    #2 rst = 1'b1; req = 4'h0;
    #2;
    check("t6_un_rst", un_q, 4'hA);
    check("t6_gnt_rst", gnt, 4'h0);
    check("t6_rv_rst", rvalid, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    settle(); settle();
    check("t6_un_after", un_q, 4'hA);
    check("t6_no_rv", rv_count - rv0, 0);

`ifdef UNION_ARB_LOCK_EN
    // lock: requester 2 keeps winning while it holds lock (the pointer was reset to 0)
    tick();
    base = grant_log.size();
    lock = 4'b0100; req = 4'b0110; wr = 4'h0;
    repeat (12) @(posedge clk);
    #1 req = 4'h0; lock = 4'h0;
    settle();
    check("lk_ngrants", grant_log.size() - base, 4);
    if (grant_log.size() >= base + 4) begin
      check("lk_g0", grant_log[base], 1);
      check("lk_g1", grant_log[base + 1], 2);
      check("lk_g2", grant_log[base + 2], 2);
      check("lk_g3", grant_log[base + 3], 2);
    end
`endif

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
